uart_irq_ctrl: RTL and testbench

UART_IRQ_CTRL -- requirements
Module: uart_irq_ctrl

---
 rtl/common_def.sv | 36 +++
 rtl/uart_char_timeout.sv | 38 +++
 rtl/uart_irq_ctrl.sv | 83 ++++++++
 tb/tb_uart_irq_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/common_def.sv
// Shared UART register-map definitions: APB addresses, IIR identification codes
// and IER bit positions used by the interrupt controller.
package common_def;

    typedef enum logic [2:0] {
        ADDR_RDR = 3'h0,
        ADDR_TDR = 3'h1,
        ADDR_IER = 3'h2,
        ADDR_IIR = 3'h3,
        ADDR_FCR = 3'h4,
        ADDR_LSR = 3'h5
    } apb_addr_e;

    localparam logic [3:0] IIR_NONE = 4'b0001;
    localparam logic [3:0] IIR_LSR  = 4'b0110;
    localparam logic [3:0] IIR_RDA  = 4'b0100;
    localparam logic [3:0] IIR_CTO  = 4'b1100;
    localparam logic [3:0] IIR_THRE = 4'b0010;

    localparam int IER_RDA  = 0;
    localparam int IER_THRE = 1;
    localparam int IER_RLS  = 2;

    // Inputs are already gated by their enables; first active source wins.
    function automatic logic [3:0] iir_encode(input logic lsr, input logic rda,
                                              input logic cto, input logic thre);
        logic [3:0] code;
        code = IIR_NONE;
        if (lsr)       code = IIR_LSR;
        else if (rda)  code = IIR_RDA;
        else if (cto)  code = IIR_CTO;
        else if (thre) code = IIR_THRE;
        return code;
    endfunction

endpackage

// File: rtl/uart_char_timeout.sv
// RX character-timeout counter and pending flag; only built with UART_IRQ_TIMEOUT_EN.
module uart_char_timeout #(
    parameter int TO_W = 16
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_rx_not_empty,
    input  logic            i_rx_activity,
    input  logic            i_rdr_rd,
    input  logic [TO_W-1:0] i_to_limit,
    output logic            o_pend_nxt
);
    localparam logic [TO_W-1:0] ONE = TO_W'(1);

    logic [TO_W-1:0] r_cnt;
    logic            r_pend;
    logic            w_count;
    logic            w_hit;

    assign w_count = i_rx_not_empty & ~i_rx_activity & ~i_rdr_rd;
    // ">=" rather than "==" so a limit lowered below the current count still fires.
    assign w_hit   = w_count && (i_to_limit != '0) && (r_cnt >= (i_to_limit - ONE));
    assign o_pend_nxt = w_hit | (r_pend & ~(i_rdr_rd | i_rx_activity));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else begin
            if (!w_count)
                r_cnt <= '0;
            else if (r_cnt < i_to_limit)
                r_cnt <= r_cnt + ONE;
            r_pend <= o_pend_nxt;
        end
    end

endmodule

// File: rtl/uart_irq_ctrl.sv
// UART interrupt prioritiser producing registered irq / IIR code.
// Define UART_IRQ_TIMEOUT_EN to include the character-timeout source.
module uart_irq_ctrl #(
    parameter int TO_W = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [2:0]      ier,
    input  logic            rx_level_hit,
    input  logic            rx_not_empty,
    input  logic            rx_activity,
    input  logic            rx_line_err,
    input  logic            tx_empty,
    input  logic [TO_W-1:0] to_limit,
    input  logic            iir_rd,
    input  logic            lsr_rd,
    input  logic            rdr_rd,
    input  logic            tdr_wr,
    output logic            irq,
    output logic [3:0]      iir_id
);
    import common_def::*;

    logic       r_lsr;
    logic       r_thre;
    logic       r_tx_hist;
    logic       r_irq;
    logic [3:0] r_iir;

    logic       w_tx_lvl;
    logic       w_lsr_nxt;
    logic       w_thre_clr;
    logic       w_thre_nxt;
    logic       w_cto_nxt;
    logic [3:0] w_iir_nxt;

`ifdef UART_IRQ_TIMEOUT_EN
    uart_char_timeout #(.TO_W(TO_W)) u_char_timeout (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_rx_not_empty (rx_not_empty),
        .i_rx_activity  (rx_activity),
        .i_rdr_rd       (rdr_rd),
        .i_to_limit     (to_limit),
        .o_pend_nxt     (w_cto_nxt)
    );
`else
    logic w_unused;
    assign w_unused  = ^{to_limit, rdr_rd, rx_activity, rx_not_empty};
    assign w_cto_nxt = 1'b0;
`endif

    // Enabling THRE while the transmitter is already idle counts as a rising edge.
    assign w_tx_lvl   = tx_empty & ier[IER_THRE];
    assign w_lsr_nxt  = rx_line_err | (r_lsr & ~lsr_rd);
    assign w_thre_clr = tdr_wr | (iir_rd && (r_iir == IIR_THRE));
    assign w_thre_nxt = (w_tx_lvl & ~r_tx_hist) | (r_thre & ~w_thre_clr);

    assign w_iir_nxt = iir_encode(w_lsr_nxt    & ier[IER_RLS],
                                  rx_level_hit & ier[IER_RDA],
                                  w_cto_nxt    & ier[IER_RDA],
                                  w_thre_nxt   & ier[IER_THRE]);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lsr     <= 1'b0;
            r_thre    <= 1'b0;
            r_tx_hist <= 1'b0;
            r_irq     <= 1'b0;
            r_iir     <= IIR_NONE;
        end else begin
            r_lsr     <= w_lsr_nxt;
            r_thre    <= w_thre_nxt;
            r_tx_hist <= w_tx_lvl;
            r_irq     <= (w_iir_nxt != IIR_NONE);
            r_iir     <= w_iir_nxt;
        end
    end

    assign irq    = r_irq;
    assign iir_id = r_iir;

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Directed bench for uart_irq_ctrl: cycle vector table plus timeout sequences.
module tb_uart_irq_ctrl;

    localparam int TO_W = 16;
`ifdef UART_IRQ_TIMEOUT_EN
    localparam logic [3:0] EXP_CTO = 4'b1100;
    localparam logic       EXP_CTO_IRQ = 1'b1;
`else
    localparam logic [3:0] EXP_CTO = 4'b0001;
    localparam logic       EXP_CTO_IRQ = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic [2:0]      ier;
    logic            rx_level_hit, rx_not_empty, rx_activity, rx_line_err, tx_empty;
    logic [TO_W-1:0] to_limit;
    logic            iir_rd, lsr_rd, rdr_rd, tdr_wr;
    logic            irq;
    logic [3:0]      iir_id;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_irq_ctrl #(.TO_W(TO_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ier          (ier),
        .rx_level_hit (rx_level_hit),
        .rx_not_empty (rx_not_empty),
        .rx_activity  (rx_activity),
        .rx_line_err  (rx_line_err),
        .tx_empty     (tx_empty),
        .to_limit     (to_limit),
        .iir_rd       (iir_rd),
        .lsr_rd       (lsr_rd),
        .rdr_rd       (rdr_rd),
        .tdr_wr       (tdr_wr),
        .irq          (irq),
        .iir_id       (iir_id)
    );

    typedef struct {
        logic       rst_n;
        logic [2:0] ier;
        logic       lvl, lerr, lsrrd, txe, iirrd, tdrwr;
        logic       e_irq;
        logic [3:0] e_iir;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic [2:0] ie, input logic lv,
                                input logic le, input logic lr, input logic te,
                                input logic ir, input logic tw, input logic ei,
                                input logic [3:0] ec);
        vec_t v;
        v.rst_n = r; v.ier = ie; v.lvl = lv; v.lerr = le; v.lsrrd = lr;
        v.txe = te; v.iirrd = ir; v.tdrwr = tw; v.e_irq = ei; v.e_iir = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] exp_iir, input logic exp_irq);
        n_checks++;
        if (iir_id !== exp_iir || irq !== exp_irq) begin
            n_errors++;
            $display("FAIL %s: got irq=%b iir_id=%b, expected irq=%b iir_id=%b",
                     name, irq, iir_id, exp_irq, exp_iir);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        rx_level_hit = 0; rx_activity = 0; rx_line_err = 0; tx_empty = 0;
        iir_rd = 0; lsr_rd = 0; rdr_rd = 0; tdr_wr = 0;
    endtask

    initial begin
        //              rst ier    lvl le lr te ir tw  irq iir
        vecs[0]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0001);
        vecs[1]  = mk(0, 3'b111, 0, 1, 0, 1, 0, 0, 0, 4'b0001);
        vecs[2]  = mk(1, 3'b111, 1, 1, 0, 0, 0, 0, 1, 4'b0110);
        vecs[3]  = mk(1, 3'b111, 1, 0, 1, 0, 0, 0, 1, 4'b0100);
        vecs[4]  = mk(1, 3'b111, 0, 0, 0, 0, 0, 0, 0, 4'b0001);
        vecs[5]  = mk(1, 3'b111, 0, 1, 1, 0, 0, 0, 1, 4'b0110);
        vecs[6]  = mk(1, 3'b111, 0, 0, 0, 0, 1, 0, 1, 4'b0110);
        vecs[7]  = mk(1, 3'b011, 0, 0, 0, 0, 0, 0, 0, 4'b0001);
        vecs[8]  = mk(1, 3'b111, 0, 0, 0, 0, 0, 0, 1, 4'b0110);
        vecs[9]  = mk(1, 3'b111, 0, 0, 1, 0, 0, 0, 0, 4'b0001);
        vecs[10] = mk(1, 3'b000, 0, 1, 0, 0, 0, 0, 0, 4'b0001);
        vecs[11] = mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0001);
        vecs[12] = mk(1, 3'b100, 0, 0, 0, 0, 0, 0, 1, 4'b0110);
        vecs[13] = mk(1, 3'b100, 0, 0, 1, 0, 0, 0, 0, 4'b0001);
        vecs[14] = mk(1, 3'b010, 0, 0, 0, 1, 0, 0, 1, 4'b0010);
        vecs[15] = mk(1, 3'b010, 0, 0, 0, 1, 1, 0, 0, 4'b0001);
        vecs[16] = mk(1, 3'b010, 0, 0, 0, 1, 0, 0, 0, 4'b0001);
        vecs[17] = mk(1, 3'b000, 0, 0, 0, 1, 0, 0, 0, 4'b0001);
        vecs[18] = mk(1, 3'b010, 0, 0, 0, 1, 0, 0, 1, 4'b0010);
        vecs[19] = mk(1, 3'b110, 0, 1, 0, 1, 0, 0, 1, 4'b0110);
        vecs[20] = mk(1, 3'b110, 0, 0, 0, 1, 1, 0, 1, 4'b0110);
        vecs[21] = mk(1, 3'b110, 0, 0, 1, 1, 0, 0, 1, 4'b0010);
        vecs[22] = mk(1, 3'b110, 0, 0, 0, 1, 0, 1, 0, 4'b0001);
        vecs[23] = mk(1, 3'b111, 1, 0, 0, 1, 0, 0, 1, 4'b0100);
        vecs[24] = mk(1, 3'b110, 1, 0, 0, 1, 0, 0, 0, 4'b0001);
        vecs[25] = mk(1, 3'b111, 0, 1, 0, 0, 0, 0, 1, 4'b0110);
        vecs[26] = mk(1, 3'b111, 0, 0, 0, 1, 0, 0, 1, 4'b0110);
        vecs[27] = mk(0, 3'b111, 0, 0, 0, 1, 0, 0, 0, 4'b0001);
        vecs[28] = mk(1, 3'b111, 0, 0, 0, 1, 0, 0, 1, 4'b0010);

        reset_n = 0; ier = 0; to_limit = '0; rx_not_empty = 0;
        idle_inputs();

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset_n      = vecs[i].rst_n;
            ier          = vecs[i].ier;
            rx_level_hit = vecs[i].lvl;
            rx_line_err  = vecs[i].lerr;
            lsr_rd       = vecs[i].lsrrd;
            tx_empty     = vecs[i].txe;
            iir_rd       = vecs[i].iirrd;
            tdr_wr       = vecs[i].tdrwr;
            tick();
            check($sformatf("vec%0d", i), vecs[i].e_iir, vecs[i].e_irq);
        end

        // Character timeout with to_limit=10: fires after the 10th counting cycle.
        @(negedge clk);
        idle_inputs(); reset_n = 0; ier = 3'b000;
        tick();
        @(negedge clk);
        reset_n = 1; ier = 3'b001; to_limit = 16'd10; rx_not_empty = 1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 10) check("cto_fire", EXP_CTO, EXP_CTO_IRQ);
            else         check($sformatf("cto_wait%0d", k), 4'b0001, 1'b0);
        end

        @(negedge clk); rdr_rd = 1;
        tick();
        check("cto_rdr_clear", 4'b0001, 1'b0);

        // Lower the limit below the running count: fires on the next counting cycle.
        @(negedge clk); rdr_rd = 0;
        for (int k = 0; k < 5; k++) tick();
        check("cto_count5", 4'b0001, 1'b0);
        @(negedge clk); to_limit = 16'd3;
        tick();
        check("cto_limit_drop", EXP_CTO, EXP_CTO_IRQ);

        @(negedge clk); rx_level_hit = 1;
        tick();
        check("rda_over_cto", 4'b0100, 1'b1);

        @(negedge clk); rx_level_hit = 0; rx_activity = 1;
        tick();
        check("cto_activity_clear", 4'b0001, 1'b0);

        // Zero limit disables the timeout entirely.
        @(negedge clk); rx_activity = 0; to_limit = '0;
        for (int k = 0; k < 20; k++) tick();
        check("cto_limit_zero", 4'b0001, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete within time budget");
        $fatal(1, "bench timeout");
    end

endmodule
